// File: rtl/cmd_push_arb.sv
// cmd_push_arb
//   Two-requester arbiter/sequencer in front of the cmd_fifo push port.
//   One requester owns the push port for a whole command, so commands are never
//   interleaved. A WT command is burst_cnt+1 consecutive beats, CMD and RD are a
//   single beat, and IDE is dropped without being forwarded. Ownership alternates
//   round-robin at command boundaries.
//
// Ports
//   wt_clk, rstn        push-domain clock, asynchronous active-low reset
//   req_valid/ready     per-requester beat handshake (bit i = requester i)
//   req_*               requester fields, requester i at [i*W +: W]
//   io_push_*           push port towards cmd_fifo (ready low = fifo full)
//   grant_id            requester currently owning the push port
//   busy                high while a command is being forwarded
//
// state   | meaning
// S_IDLE  | no owner; arbitrate among valid requesters (one bubble cycle)
// S_BURST | owner's beats pass straight through until its last beat fires

module cmd_push_arb #(
  parameter int TYPE_WIDTH = 2,
  parameter int ADDR_WIDTH = 27,
  parameter int BRST_WIDTH = 6,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = 16
) (
  input  logic                    wt_clk,
  input  logic                    rstn,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*TYPE_WIDTH-1:0] req_type,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*BRST_WIDTH-1:0] req_burst_cnt,
  input  logic [2*DATA_WIDTH-1:0] req_wt_data,
  input  logic [2*MASK_WIDTH-1:0] req_wt_mask,
  output logic                    io_push_valid,
  input  logic                    io_push_ready,
  output logic [TYPE_WIDTH-1:0]   io_push_cmd_type,
  output logic [ADDR_WIDTH-1:0]   io_push_addr,
  output logic [BRST_WIDTH-1:0]   io_push_burst_cnt,
  output logic [DATA_WIDTH-1:0]   io_push_wt_data,
  output logic [MASK_WIDTH-1:0]   io_push_wt_mask,
  output logic                    grant_id,
  output logic                    busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  localparam logic [TYPE_WIDTH-1:0] T_IDE = TYPE_WIDTH'(0);
  localparam logic [TYPE_WIDTH-1:0] T_WT  = TYPE_WIDTH'(2);
  localparam logic [BRST_WIDTH-1:0] CNT_ONE = BRST_WIDTH'(1);

  state_t                r_state;
  logic                  r_grant_id;
  logic                  r_rr_ptr;
  logic [BRST_WIDTH-1:0] r_beat_cnt;
  logic [TYPE_WIDTH-1:0] r_type;
  logic [BRST_WIDTH-1:0] r_burst_cnt;

  logic                  w_arb_id;
  logic [TYPE_WIDTH-1:0] w_arb_type;
  logic [BRST_WIDTH-1:0] w_arb_burst;
  logic                  w_is_ide;
  logic                  w_fire;
  logic                  w_last;

  // Round-robin pointer wins if it is requesting, otherwise the other side.
  assign w_arb_id    = req_valid[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
  assign w_arb_type  = w_arb_id ? req_type[2*TYPE_WIDTH-1:TYPE_WIDTH]
                                : req_type[TYPE_WIDTH-1:0];
  assign w_arb_burst = w_arb_id ? req_burst_cnt[2*BRST_WIDTH-1:BRST_WIDTH]
                                : req_burst_cnt[BRST_WIDTH-1:0];

  // Forwarded fields always follow the latched owner; they only matter
  // while io_push_valid is high.
  assign io_push_cmd_type  = r_grant_id ? req_type[2*TYPE_WIDTH-1:TYPE_WIDTH]
                                        : req_type[TYPE_WIDTH-1:0];
  assign io_push_addr      = r_grant_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                        : req_addr[ADDR_WIDTH-1:0];
  assign io_push_burst_cnt = r_grant_id ? req_burst_cnt[2*BRST_WIDTH-1:BRST_WIDTH]
                                        : req_burst_cnt[BRST_WIDTH-1:0];
  assign io_push_wt_data   = r_grant_id ? req_wt_data[2*DATA_WIDTH-1:DATA_WIDTH]
                                        : req_wt_data[DATA_WIDTH-1:0];
  assign io_push_wt_mask   = r_grant_id ? req_wt_mask[2*MASK_WIDTH-1:MASK_WIDTH]
                                        : req_wt_mask[MASK_WIDTH-1:0];

  assign w_is_ide = (r_type == T_IDE);
  assign grant_id = r_grant_id;
  assign busy     = (r_state == S_BURST);

  always_comb begin
    req_ready     = 2'b00;
    io_push_valid = 1'b0;
    if (r_state == S_BURST) begin
      if (w_is_ide) begin
        // IDE is consumed from the requester but never reaches the fifo.
        req_ready[r_grant_id] = 1'b1;
      end else begin
        io_push_valid         = req_valid[r_grant_id];
        req_ready[r_grant_id] = io_push_ready;
      end
    end
  end

  assign w_fire = io_push_valid && io_push_ready;
  // Compare against the burst count latched at grant; the live field may change.
  assign w_last = w_fire && ((r_type != T_WT) || (r_beat_cnt == r_burst_cnt));

  always_ff @(posedge wt_clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_grant_id  <= 1'b0;
      r_rr_ptr    <= 1'b0;
      r_beat_cnt  <= '0;
      r_type      <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_grant_id  <= w_arb_id;
            r_type      <= w_arb_type;
            r_burst_cnt <= w_arb_burst;
            r_beat_cnt  <= '0;
            r_state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_is_ide) begin
            // A dropped IDE still counts as a command boundary for fairness.
            r_rr_ptr <= ~r_grant_id;
            r_state  <= S_IDLE;
          end else if (w_last) begin
            r_beat_cnt <= '0;
            r_rr_ptr   <= ~r_grant_id;
            r_state    <= S_IDLE;
          end else if (w_fire) begin
            r_beat_cnt <= r_beat_cnt + CNT_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_push_arb.sv
module tb_cmd_push_arb;

  typedef struct {
    logic [1:0]   t;
    logic [26:0]  a;
    logic [5:0]   b;
    logic [127:0] d;
    logic [15:0]  m;
  } beat_t;

  typedef struct {
    logic         gid;
    logic [1:0]   t;
    logic [127:0] d;
  } pushed_t;

  logic         wt_clk;
  logic         rstn;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [3:0]   req_type;
  logic [53:0]  req_addr;
  logic [11:0]  req_burst_cnt;
  logic [255:0] req_wt_data;
  logic [31:0]  req_wt_mask;
  logic         io_push_valid;
  logic         io_push_ready;
  logic [1:0]   io_push_cmd_type;
  logic [26:0]  io_push_addr;
  logic [5:0]   io_push_burst_cnt;
  logic [127:0] io_push_wt_data;
  logic [15:0]  io_push_wt_mask;
  logic         grant_id;
  logic         busy;

  cmd_push_arb dut (
    .wt_clk            (wt_clk),
    .rstn              (rstn),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_type          (req_type),
    .req_addr          (req_addr),
    .req_burst_cnt     (req_burst_cnt),
    .req_wt_data       (req_wt_data),
    .req_wt_mask       (req_wt_mask),
    .io_push_valid     (io_push_valid),
    .io_push_ready     (io_push_ready),
    .io_push_cmd_type  (io_push_cmd_type),
    .io_push_addr      (io_push_addr),
    .io_push_burst_cnt (io_push_burst_cnt),
    .io_push_wt_data   (io_push_wt_data),
    .io_push_wt_mask   (io_push_wt_mask),
    .grant_id          (grant_id),
    .busy              (busy)
  );

  initial wt_clk = 1'b0;
  always #5 wt_clk = ~wt_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Requester queues: the front beat is presented until it is accepted.
  beat_t   q0[$];
  beat_t   q1[$];
  pushed_t plog[$];
  logic [1:0]  acc = 2'b00;
  logic [63:0] rdy_pat = '1;
  int busy_cnt = 0;
  int rdy0_cnt = 0;

  // Behavioural model: owner, command type and number of beats still owed.
  bit       m_busy  = 0;
  bit       m_owner = 0;
  bit       m_rr    = 0;
  bit [1:0] m_type  = 0;
  int       m_left  = 0;

  initial begin
    beat_t tmp;
    req_valid = 2'b00; req_type = '0; req_addr = '0; req_burst_cnt = '0;
    req_wt_data = '0; req_wt_mask = '0; io_push_ready = 1'b1;
    forever begin
      @(posedge wt_clk); #1;
      if (acc[0] && q0.size() > 0) tmp = q0.pop_front();
      if (acc[1] && q1.size() > 0) tmp = q1.pop_front();
      req_valid[0] = (q0.size() > 0);
      if (q0.size() > 0) begin
        req_type[1:0] = q0[0].t; req_addr[26:0] = q0[0].a; req_burst_cnt[5:0] = q0[0].b;
        req_wt_data[127:0] = q0[0].d; req_wt_mask[15:0] = q0[0].m;
      end
      req_valid[1] = (q1.size() > 0);
      if (q1.size() > 0) begin
        req_type[3:2] = q1[0].t; req_addr[53:27] = q1[0].a; req_burst_cnt[11:6] = q1[0].b;
        req_wt_data[255:128] = q1[0].d; req_wt_mask[31:16] = q1[0].m;
      end
      io_push_ready = rdy_pat[0];
      rdy_pat = {1'b1, rdy_pat[63:1]};
    end
  end

  // Compare process: outputs are stable mid-cycle; then advance the model.
  always @(negedge wt_clk) begin
    logic       e_pv;
    logic [1:0] e_rdy;
    logic [1:0] o_t;
    pushed_t    p;
    if (!rstn) begin
      chk("rst_busy", busy, 0);
      chk("rst_push_valid", io_push_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_grant", grant_id, 0);
      m_busy = 0; m_owner = 0; m_rr = 0; m_left = 0;
      acc = 2'b00;
    end else begin
      e_pv = 0; e_rdy = 2'b00;
      if (m_busy) begin
        if (m_type == 2'd0) e_rdy[m_owner] = 1'b1;
        else begin
          e_pv = req_valid[m_owner];
          e_rdy[m_owner] = io_push_ready;
        end
      end
      chk("busy", busy, m_busy);
      chk("grant", grant_id, m_owner);
      chk("push_valid", io_push_valid, e_pv);
      chk("req_ready", req_ready, e_rdy);
      if (e_pv) begin
        chk("push_type", io_push_cmd_type, m_owner ? req_type[3:2] : req_type[1:0]);
        chk("push_addr", io_push_addr, m_owner ? req_addr[53:27] : req_addr[26:0]);
        chk("push_burst", io_push_burst_cnt, m_owner ? req_burst_cnt[11:6] : req_burst_cnt[5:0]);
        chk("push_data", io_push_wt_data, m_owner ? req_wt_data[255:128] : req_wt_data[127:0]);
        chk("push_mask", io_push_wt_mask, m_owner ? req_wt_mask[31:16] : req_wt_mask[15:0]);
      end
      if (io_push_valid && io_push_ready) begin
        p.gid = grant_id; p.t = io_push_cmd_type; p.d = io_push_wt_data;
        plog.push_back(p);
      end
      if (busy) busy_cnt++;
      if (req_ready[0]) rdy0_cnt++;
      acc = req_valid & req_ready;
      if (!m_busy) begin
        if (|req_valid) begin
          m_owner = req_valid[m_rr] ? m_rr : !m_rr;
          o_t = m_owner ? req_type[3:2] : req_type[1:0];
          m_type = o_t;
          m_left = (o_t == 2'd2) ? int'(m_owner ? req_burst_cnt[11:6] : req_burst_cnt[5:0]) + 1 : 1;
          m_busy = 1;
        end
      end else if (m_type == 2'd0) begin
        m_busy = 0; m_rr = !m_owner;
      end else if (e_pv && io_push_ready) begin
        m_left--;
        if (m_left == 0) begin m_busy = 0; m_rr = !m_owner; end
      end
    end
  end

  task automatic push_cmd(input int r, input logic [1:0] t, input int burst, input int base,
                          input int alt_b = 0, input int alt_from = 1000);
    beat_t bt;
    int n;
    n = (t == 2'd2) ? burst + 1 : 1;
    for (int k = 0; k < n; k++) begin
      bt.t = t; bt.a = 27'(base); bt.d = 128'(base + k); bt.m = 16'(k + 1);
      bt.b = (k >= alt_from) ? 6'(alt_b) : 6'(burst);
      if (r == 0) q0.push_back(bt); else q1.push_back(bt);
    end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    bit done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge wt_clk); #1;
      if (q0.size() == 0 && q1.size() == 0 && !m_busy) done = 1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL timeout_%s actual=busy required=idle", nm);
    end
  endtask

  task automatic do_reset();
    @(posedge wt_clk); #2;
    rstn = 1'b0; q0.delete(); q1.delete();
    repeat (2) @(posedge wt_clk);
    #2 rstn = 1'b1;
  endtask

  initial begin
    int errs;
    rstn = 1'b0;
    repeat (3) @(posedge wt_clk);
    #2 rstn = 1'b1;

    // 1: req0 WT burst 7, ready always high
    @(posedge wt_clk); #2;
    plog.delete(); busy_cnt = 0;
    push_cmd(0, 2'd2, 7, 100);
    wait_idle(60, "t1");
    chk("t1_beats", plog.size(), 8);
    chk("t1_busy_cycles", busy_cnt, 8);
    errs = 0;
    foreach (plog[k]) if (plog[k].gid !== 1'b0 || plog[k].d !== 128'(100 + k) || plog[k].t !== 2'd2) errs++;
    chk("t1_seq_errs", errs, 0);
    // rr_ptr now favours requester 1
    @(posedge wt_clk); #2;
    plog.delete();
    push_cmd(0, 2'd1, 0, 150);
    push_cmd(1, 2'd1, 0, 160);
    wait_idle(30, "t1b");
    chk("t1b_beats", plog.size(), 2);
    if (plog.size() == 2) begin
      chk("t1b_first_gid", plog[0].gid, 1);
      chk("t1b_second_gid", plog[1].gid, 0);
    end

    // 2: simultaneous from reset, req0 WT 3 and req1 RD
    do_reset();
    @(posedge wt_clk); #2;
    plog.delete();
    push_cmd(0, 2'd2, 3, 200);
    push_cmd(1, 2'd3, 0, 300);
    wait_idle(40, "t2");
    chk("t2_beats", plog.size(), 5);
    if (plog.size() == 5) begin
      errs = 0;
      for (int k = 0; k < 4; k++) if (plog[k].gid !== 1'b0 || plog[k].d !== 128'(200 + k)) errs++;
      chk("t2_req0_errs", errs, 0);
      chk("t2_last_gid", plog[4].gid, 1);
      chk("t2_last_type", plog[4].t, 3);
    end

    // 3: req1 WT 3 with two stall cycles inside the burst
    @(posedge wt_clk); #2;
    plog.delete(); busy_cnt = 0;
    rdy_pat = ~64'h0C;
    push_cmd(1, 2'd2, 3, 400);
    wait_idle(40, "t3");
    chk("t3_beats", plog.size(), 4);
    chk("t3_busy_cycles", busy_cnt, 6);
    errs = 0;
    foreach (plog[k]) if (plog[k].gid !== 1'b1 || plog[k].d !== 128'(400 + k)) errs++;
    chk("t3_seq_errs", errs, 0);

    // 4: req0 IDE is dropped
    @(posedge wt_clk); #2;
    plog.delete(); busy_cnt = 0; rdy0_cnt = 0;
    push_cmd(0, 2'd0, 0, 450);
    wait_idle(20, "t4");
    chk("t4_beats", plog.size(), 0);
    chk("t4_ready_pulses", rdy0_cnt, 1);
    chk("t4_busy_cycles", busy_cnt, 1);

    // 5: reset in the middle of a WT 7 burst
    @(posedge wt_clk); #2;
    plog.delete();
    push_cmd(0, 2'd2, 7, 500);
    begin
      bit seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge wt_clk); #1;
        if (plog.size() >= 3) seen = 1;
      end
      chk("t5_reached_beat3", seen, 1);
    end
    @(posedge wt_clk); #2;
    rstn = 1'b0; q0.delete(); q1.delete();
    #1;
    chk("t5_busy_now", busy, 0);
    chk("t5_valid_now", io_push_valid, 0);
    chk("t5_ready_now", req_ready, 0);
    chk("t5_grant_now", grant_id, 0);
    repeat (2) @(posedge wt_clk);
    #2 rstn = 1'b1;
    @(posedge wt_clk); #2;
    plog.delete();
    push_cmd(1, 2'd3, 0, 600);
    push_cmd(0, 2'd3, 0, 700);
    wait_idle(30, "t5");
    chk("t5_beats", plog.size(), 2);
    if (plog.size() == 2) begin
      chk("t5_first_gid", plog[0].gid, 0);
      chk("t5_first_data", plog[0].d, 700);
      chk("t5_second_gid", plog[1].gid, 1);
    end

    // 6: max burst, live burst_cnt changes mid-burst
    @(posedge wt_clk); #2;
    plog.delete();
    push_cmd(0, 2'd2, 63, 1000, 5, 10);
    wait_idle(200, "t6");
    chk("t6_beats", plog.size(), 64);
    errs = 0;
    foreach (plog[k]) if (plog[k].gid !== 1'b0 || plog[k].d !== 128'(1000 + k)) errs++;
    chk("t6_seq_errs", errs, 0);

    repeat (3) @(posedge wt_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
